// File: rtl/aes_mon_pkg.sv
// Shared types for the AES ciphertext consistency monitor: FSM states,
// sticky status flags and datapath widths.
package aes_mon_pkg;

    localparam int unsigned DataWidth   = 128;
    localparam int unsigned KeyTagWidth = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CHECK = 2'd2,
        ST_ALARM = 2'd3
    } mon_state_e;

    typedef struct packed {
        logic alarm;
        logic timeout;
        logic proto_err;
        logic ref_valid;
    } mon_status_t;

endpackage

// File: rtl/aes_mon_wdog.sv
// Watchdog for the monitor: counts enabled cycles from a synchronous clear and
// flags expiry once the count reaches TimeoutCycles-1 (it then holds there).
module aes_mon_wdog #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] r_count;

    // NOTE: sequential state is written only with <= so every register samples
    // pre-edge values, independent of the order blocks are evaluated in.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != LastCount)) begin
            r_count <= r_count + CntW'(1);
        end
    end

    assign expired_o = (r_count == LastCount);

endmodule

// File: rtl/aes_ct_consistency_mon.sv
// Repeat-encryption consistency monitor for aes_core: identical (plaintext, key)
// fingerprints must always produce the identical ciphertext.
module aes_ct_consistency_mon
    import aes_mon_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned IterWidth     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DataWidth-1:0]   data_in_i,
    input  logic [KeyTagWidth-1:0] key_tag_i,
    input  logic                   output_valid_i,
    input  logic [DataWidth-1:0]   data_out_i,
    input  logic                   clear_i,
    output logic                   alarm_o,
    output logic                   timeout_o,
    output logic                   proto_err_o,
    output logic                   ref_valid_o,
    output logic [IterWidth-1:0]   iter_o,
    output logic [DataWidth-1:0]   obs_ct_o
);

    mon_state_e  r_state;
    mon_state_e  w_state_nxt;
    mon_status_t r_status;

    logic [DataWidth-1:0]   r_pend_pt;
    logic [KeyTagWidth-1:0] r_pend_key;
    logic [DataWidth-1:0]   r_ct;
    logic [DataWidth-1:0]   r_ref_pt;
    logic [KeyTagWidth-1:0] r_ref_key;
    logic [DataWidth-1:0]   r_ref_ct;
    logic [DataWidth-1:0]   r_obs_ct;
    logic [IterWidth-1:0]   r_iter;

    logic w_wdog_expired;
    logic w_fp_match;
    logic w_ref_hit;
    logic w_ct_match;

    logic w_accept_start;
    logic w_capture_ct;
    logic w_timeout_hit;
    logic w_proto_hit;
    logic w_ref_load;
    logic w_ct_ok;
    logic w_ct_bad;

    aes_mon_wdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_accept_start || clear_i),
        .en_i     (r_state == ST_BUSY),
        .expired_o(w_wdog_expired)
    );

    assign w_fp_match = (r_pend_pt == r_ref_pt) && (r_pend_key == r_ref_key);
    assign w_ref_hit  = r_status.ref_valid && w_fp_match;
    assign w_ct_match = (r_ct == r_ref_ct);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) w_state_nxt = ST_BUSY;
                end
                ST_BUSY: begin
                    if (output_valid_i)      w_state_nxt = ST_CHECK;
                    else if (w_wdog_expired) w_state_nxt = ST_ALARM;
                end
                ST_CHECK: begin
                    w_state_nxt = (w_ref_hit && !w_ct_match) ? ST_ALARM : ST_IDLE;
                end
                ST_ALARM: begin
                    w_state_nxt = ST_ALARM;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath strobes; clear_i is folded into the register block so it wins.
    always_comb begin
        w_accept_start = 1'b0;
        w_capture_ct   = 1'b0;
        w_timeout_hit  = 1'b0;
        w_proto_hit    = 1'b0;
        w_ref_load     = 1'b0;
        w_ct_ok        = 1'b0;
        w_ct_bad       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept_start = start_i && !clear_i;
            end
            ST_BUSY: begin
                w_capture_ct  = output_valid_i;
                w_timeout_hit = !output_valid_i && w_wdog_expired;
                w_proto_hit   = start_i;
            end
            ST_CHECK: begin
                w_proto_hit = start_i;
                w_ref_load  = !w_ref_hit;
                w_ct_ok     = w_ref_hit && w_ct_match;
                w_ct_bad    = w_ref_hit && !w_ct_match;
            end
            default: begin
            end
        endcase
    end

    // NOTE: the reference and fingerprint registers are reset explicitly; a
    // stale reference after reset would turn the first compare into a false alarm.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_status   <= '0;
            r_pend_pt  <= '0;
            r_pend_key <= '0;
            r_ct       <= '0;
            r_ref_pt   <= '0;
            r_ref_key  <= '0;
            r_ref_ct   <= '0;
            r_obs_ct   <= '0;
            r_iter     <= '0;
        end else begin
            if (w_accept_start) begin
                r_pend_pt  <= data_in_i;
                r_pend_key <= key_tag_i;
            end
            if (w_capture_ct) begin
                r_ct <= data_out_i;
            end
            if (w_timeout_hit) begin
                r_status.timeout <= 1'b1;
            end
            if (w_proto_hit) begin
                r_status.proto_err <= 1'b1;
            end
            if (w_ref_load) begin
                r_ref_pt           <= r_pend_pt;
                r_ref_key          <= r_pend_key;
                r_ref_ct           <= r_ct;
                r_status.ref_valid <= 1'b1;
                r_iter             <= IterWidth'(1);
            end
            if (w_ct_ok && !(&r_iter)) begin
                r_iter <= r_iter + IterWidth'(1);
            end
            if (w_ct_bad) begin
                r_status.alarm <= 1'b1;
                r_obs_ct       <= r_ct;
            end
        end
    end

    assign alarm_o     = r_status.alarm;
    assign timeout_o   = r_status.timeout;
    assign proto_err_o = r_status.proto_err;
    assign ref_valid_o = r_status.ref_valid;
    assign iter_o      = r_iter;
    assign obs_ct_o    = r_obs_ct;

endmodule

// File: tb/tb_aes_ct_consistency_mon.sv
// Self-checking bench for aes_ct_consistency_mon against a transaction-level
// model of the reference/iteration/alarm rules.
module tb_aes_ct_consistency_mon;

    localparam int unsigned TO = 256;
    localparam int unsigned IW = 16;
    localparam int          IterMax = (1 << IW) - 1;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] data_in_i = '0;
    logic [31:0]  key_tag_i = '0;
    logic         output_valid_i = 1'b0;
    logic [127:0] data_out_i = '0;
    logic         clear_i = 1'b0;
    logic         alarm_o;
    logic         timeout_o;
    logic         proto_err_o;
    logic         ref_valid_o;
    logic [IW-1:0] iter_o;
    logic [127:0] obs_ct_o;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model state
    logic         m_ref_valid;
    logic [127:0] m_ref_pt;
    logic [31:0]  m_ref_key;
    logic [127:0] m_ref_ct;
    int           m_iter;
    logic         m_alarm;
    logic [127:0] m_obs;

    localparam logic [31:0]  KeyA = 32'h01234567;
    localparam logic [127:0] PtA  = {4{32'h89ABCDEF}};

    aes_ct_consistency_mon #(
        .TimeoutCycles(TO),
        .IterWidth    (IW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .data_in_i     (data_in_i),
        .key_tag_i     (key_tag_i),
        .output_valid_i(output_valid_i),
        .data_out_i    (data_out_i),
        .clear_i       (clear_i),
        .alarm_o       (alarm_o),
        .timeout_o     (timeout_o),
        .proto_err_o   (proto_err_o),
        .ref_valid_o   (ref_valid_o),
        .iter_o        (iter_o),
        .obs_ct_o      (obs_ct_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL sim_time_limit: got no completion want finish before limit");
        $fatal(1, "time limit");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in cipher: any deterministic function of the fingerprint will do.
    function automatic logic [127:0] golden(input logic [127:0] pt, input logic [31:0] key);
        return {pt[70:0], pt[127:71]} ^ {4{key}} ^ 128'hC3A5_0F1E_7788_9911_2468_ACE0_1357_9BDF;
    endfunction

    function automatic void model_clear();
        m_ref_valid = 1'b0;
        m_ref_pt    = '0;
        m_ref_key   = '0;
        m_ref_ct    = '0;
        m_iter      = 0;
        m_alarm     = 1'b0;
        m_obs       = '0;
    endfunction

    // One completed encryption as seen by the monitor's rules.
    function automatic void model_done(input logic [127:0] pt, input logic [31:0] key,
                                       input logic [127:0] ct);
        if (!m_ref_valid || pt != m_ref_pt || key != m_ref_key) begin
            m_ref_valid = 1'b1;
            m_ref_pt    = pt;
            m_ref_key   = key;
            m_ref_ct    = ct;
            m_iter      = 1;
        end else if (ct == m_ref_ct) begin
            m_iter = (m_iter < IterMax) ? m_iter + 1 : IterMax;
        end else begin
            m_alarm = 1'b1;
            m_obs   = ct;
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; output_valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        model_clear();
    endtask

    // start, lat BUSY cycles without valid, valid, CHECK, back to IDLE/ALARM
    task automatic run_enc(input logic [127:0] pt, input logic [31:0] key,
                           input logic [127:0] ct, input int lat, output logic alarm_at_check);
        start_i = 1'b1; data_in_i = pt; key_tag_i = key;
        tick();
        start_i = 1'b0; data_in_i = rand128(); key_tag_i = $urandom;
        output_valid_i = 1'b0;
        repeat (lat) begin
            data_out_i = rand128();
            tick();
        end
        output_valid_i = 1'b1; data_out_i = ct;
        tick();
        output_valid_i = 1'($urandom_range(0, 1));
        data_out_i = rand128();
        alarm_at_check = alarm_o;
        tick();
        output_valid_i = 1'b0;
        model_done(pt, key, ct);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; clear_i = 1'b1; data_in_i = PtA; key_tag_i = KeyA;
        tick();
        rst_i = 1'b0; start_i = 1'b0; clear_i = 1'b0;
        model_clear();
        n_checks++;
        if ({alarm_o, timeout_o, proto_err_o, ref_valid_o} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b want 0000", {alarm_o, timeout_o, proto_err_o, ref_valid_o});
        end
        n_checks++;
        if (iter_o !== '0 || obs_ct_o !== '0) begin
            n_errors++;
            $display("FAIL reset_iter_obs: got iter=%0d obs=%h want 0/0", iter_o, obs_ct_o);
        end
        // start under reset must not have been taken: valid now is ignored
        output_valid_i = 1'b1; data_out_i = rand128();
        tick();
        output_valid_i = 1'b0;
        tick();
        n_checks++;
        if (ref_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got ref_valid=%b want 0", ref_valid_o);
        end
    endtask

    task automatic test_stable();
        logic a;
        logic [127:0] ct;
        do_reset();
        ct = rand128();
        for (int i = 0; i < 300; i++) begin
            run_enc(PtA, KeyA, ct, $urandom_range(0, 6), a);
            n_checks++;
            if (iter_o !== IW'(m_iter) || alarm_o !== m_alarm) begin
                n_errors++;
                $display("FAIL stable_iter[%0d]: got iter=%0d alarm=%b want %0d/%b",
                         i, iter_o, alarm_o, m_iter, m_alarm);
            end
        end
        n_checks++;
        if (alarm_o !== 1'b0 || iter_o !== IW'(300) || ref_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL stable_final: got alarm=%b iter=%0d ref_valid=%b want 0/300/1",
                     alarm_o, iter_o, ref_valid_o);
        end
    endtask

    task automatic test_flip();
        logic a;
        logic [127:0] ct;
        do_reset();
        ct = rand128();
        for (int i = 1; i <= 149; i++) run_enc(PtA, KeyA, ct, $urandom_range(0, 3), a);
        run_enc(PtA, KeyA, ct ^ 128'h1, 2, a);
        n_checks++;
        if (a !== 1'b0 || alarm_o !== 1'b1 || m_alarm !== 1'b1) begin
            n_errors++;
            $display("FAIL flip_alarm_timing: got check=%b after=%b want 0/1", a, alarm_o);
        end
        n_checks++;
        if (iter_o !== IW'(149)) begin
            n_errors++;
            $display("FAIL flip_iter: got %0d want 149", iter_o);
        end
        n_checks++;
        if (obs_ct_o !== m_obs) begin
            n_errors++;
            $display("FAIL flip_obs: got %h want %h", obs_ct_o, m_obs);
        end
        // start in ALARM is ignored and is not a protocol error
        start_i = 1'b1; data_in_i = PtA; key_tag_i = KeyA;
        tick();
        start_i = 1'b0;
        tick();
        n_checks++;
        if (proto_err_o !== 1'b0 || alarm_o !== 1'b1 || iter_o !== IW'(149)) begin
            n_errors++;
            $display("FAIL alarm_start_ignored: got proto=%b alarm=%b iter=%0d want 0/1/149",
                     proto_err_o, alarm_o, iter_o);
        end
    endtask

    task automatic test_reload();
        logic a;
        logic [127:0] ct_a, ct_b;
        do_reset();
        ct_a = rand128();
        ct_b = rand128();
        for (int i = 0; i < 10; i++) run_enc(PtA, KeyA, ct_a, $urandom_range(0, 4), a);
        n_checks++;
        if (iter_o !== IW'(10)) begin
            n_errors++;
            $display("FAIL reload_pre: got iter=%0d want 10", iter_o);
        end
        run_enc('0, KeyA, ct_b, 1, a);
        n_checks++;
        if (iter_o !== IW'(1) || alarm_o !== 1'b0 || ref_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL reload: got iter=%0d alarm=%b ref_valid=%b want 1/0/1",
                     iter_o, alarm_o, ref_valid_o);
        end
        // the new reference is in force: repeat counts up
        run_enc('0, KeyA, ct_b, 0, a);
        n_checks++;
        if (iter_o !== IW'(m_iter) || m_iter != 2) begin
            n_errors++;
            $display("FAIL reload_repeat: got iter=%0d want 2", iter_o);
        end
    endtask

    task automatic test_timeout();
        logic a;
        do_reset();
        start_i = 1'b1; data_in_i = PtA; key_tag_i = KeyA;
        tick();
        start_i = 1'b0;
        repeat (TO - 1) tick();
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_early: got %b want 0", timeout_o);
        end
        tick();
        n_checks++;
        if (timeout_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_set: got %b want 1", timeout_o);
        end
        // ALARM: start raises no proto_err and a late valid is ignored
        start_i = 1'b1;
        tick();
        start_i = 1'b0; output_valid_i = 1'b1; data_out_i = rand128();
        tick();
        output_valid_i = 1'b0;
        tick();
        n_checks++;
        if (proto_err_o !== 1'b0 || ref_valid_o !== 1'b0 || timeout_o !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_alarm_state: got proto=%b ref_valid=%b timeout=%b want 0/0/1",
                     proto_err_o, ref_valid_o, timeout_o);
        end
        do_clear();
        run_enc(PtA, KeyA, golden(PtA, KeyA), TO - 1, a);
        n_checks++;
        if (timeout_o !== 1'b0 || ref_valid_o !== 1'b1 || iter_o !== IW'(m_iter)) begin
            n_errors++;
            $display("FAIL timeout_boundary: got timeout=%b ref_valid=%b iter=%0d want 0/1/%0d",
                     timeout_o, ref_valid_o, iter_o, m_iter);
        end
    endtask

    task automatic test_proto();
        logic a;
        logic [127:0] ct;
        do_reset();
        ct = golden(PtA, KeyA);
        run_enc(PtA, KeyA, ct, 2, a);
        start_i = 1'b1; data_in_i = PtA; key_tag_i = KeyA;
        tick();
        start_i = 1'b0;
        tick();
        start_i = 1'b1; data_in_i = rand128(); key_tag_i = ~KeyA;
        tick();
        start_i = 1'b0;
        tick();
        output_valid_i = 1'b1; data_out_i = ct;
        tick();
        output_valid_i = 1'b0; start_i = 1'b1; data_in_i = rand128();
        tick();
        start_i = 1'b0;
        model_done(PtA, KeyA, ct);
        n_checks++;
        if (proto_err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL proto_flag: got %b want 1", proto_err_o);
        end
        n_checks++;
        if (iter_o !== IW'(m_iter) || alarm_o !== 1'b0 || m_iter != 2) begin
            n_errors++;
            $display("FAIL proto_iter: got iter=%0d alarm=%b want %0d/0", iter_o, alarm_o, m_iter);
        end
        // start in CHECK was dropped: a valid now lands in IDLE and is ignored
        output_valid_i = 1'b1; data_out_i = rand128();
        tick();
        output_valid_i = 1'b0;
        tick();
        n_checks++;
        if (iter_o !== IW'(2) || alarm_o !== 1'b0) begin
            n_errors++;
            $display("FAIL proto_check_start: got iter=%0d alarm=%b want 2/0", iter_o, alarm_o);
        end
    endtask

    task automatic test_clear_reset();
        logic a;
        logic [127:0] ct;
        do_reset();
        ct = rand128();
        run_enc(PtA, KeyA, ct, 1, a);
        run_enc(PtA, KeyA, ct ^ 128'h20, 1, a);
        clear_i = 1'b1; start_i = 1'b1; data_in_i = PtA; key_tag_i = KeyA;
        tick();
        clear_i = 1'b0; start_i = 1'b0;
        model_clear();
        n_checks++;
        if ({alarm_o, timeout_o, proto_err_o, ref_valid_o} !== 4'b0000 || iter_o !== '0 || obs_ct_o !== '0) begin
            n_errors++;
            $display("FAIL clear_outputs: got flags=%b iter=%0d obs=%h want all 0",
                     {alarm_o, timeout_o, proto_err_o, ref_valid_o}, iter_o, obs_ct_o);
        end
        output_valid_i = 1'b1; data_out_i = rand128();
        tick();
        output_valid_i = 1'b0;
        tick();
        n_checks++;
        if (ref_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_over_start: got ref_valid=%b want 0", ref_valid_o);
        end
        run_enc(PtA, KeyA, ct, 0, a);
        start_i = 1'b1; data_in_i = PtA; key_tag_i = KeyA;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        model_clear();
        n_checks++;
        if ({alarm_o, timeout_o, proto_err_o, ref_valid_o} !== 4'b0000 || iter_o !== '0) begin
            n_errors++;
            $display("FAIL busy_reset: got flags=%b iter=%0d want 0/0",
                     {alarm_o, timeout_o, proto_err_o, ref_valid_o}, iter_o);
        end
        output_valid_i = 1'b1; data_out_i = ct;
        tick();
        output_valid_i = 1'b0;
        tick();
        n_checks++;
        if (ref_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_reset_discard: got ref_valid=%b want 0", ref_valid_o);
        end
        run_enc(PtA, KeyA, ct, 0, a);
        n_checks++;
        if (iter_o !== IW'(1) || ref_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_reset_idle: got iter=%0d ref_valid=%b want 1/1", iter_o, ref_valid_o);
        end
    endtask

    // Back-to-back random traffic over a few fingerprints with rare corruption.
    task automatic test_back_to_back();
        logic a;
        logic [127:0] pts [2];
        logic [31:0]  keys [2];
        logic [127:0] pt, ct;
        logic [31:0]  key;
        do_reset();
        pts[0] = rand128(); pts[1] = rand128();
        keys[0] = $urandom; keys[1] = $urandom;
        for (int i = 0; i < 80; i++) begin
            pt  = pts[$urandom_range(0, 1)];
            key = keys[$urandom_range(0, 1)];
            ct  = golden(pt, key);
            if ($urandom_range(0, 15) == 0) ct[$urandom_range(0, 127)] ^= 1'b1;
            run_enc(pt, key, ct, $urandom_range(0, 3), a);
            n_checks++;
            if (alarm_o !== m_alarm || iter_o !== IW'(m_iter) || ref_valid_o !== m_ref_valid) begin
                n_errors++;
                $display("FAIL b2b[%0d]: got alarm=%b iter=%0d ref_valid=%b want %b/%0d/%b",
                         i, alarm_o, iter_o, ref_valid_o, m_alarm, m_iter, m_ref_valid);
            end
            if (m_alarm) begin
                n_checks++;
                if (obs_ct_o !== m_obs) begin
                    n_errors++;
                    $display("FAIL b2b_obs[%0d]: got %h want %h", i, obs_ct_o, m_obs);
                end
                do_clear();
            end
        end
    endtask

    initial begin
        test_reset();
        test_stable();
        test_flip();
        test_reload();
        test_timeout();
        test_proto();
        test_clear_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
